// File: rtl/spi_bus_arbiter.sv
// -----------------------------------------------------------------------------
// spi_bus_arbiter
//
// Shares one SPI master between two requesters. Port 0 is the display
// controller and port 1 is an auxiliary device such as flash or touch. The bus
// is granted per transaction and held across a multi-byte burst. Each port
// gets its own active-low chip select. Byte starts from the owner are forwarded
// to the SPI master, and each received byte is returned to the owner with a
// one-cycle valid pulse.
//
// Build option:
//   SPI_BUS_ARB_ROUND_ROBIN_EN  defined     -> round-robin arbitration. On
//                                              simultaneous requests, the port
//                                              not granted last wins.
//                               not defined -> fixed priority. Port 0 always
//                                              wins.
//
// Parameters:
//   CS_GUARD_CYCLES  idle cycles with both chip selects high after a release
//                    (valid range 1..15).
//
// Ports:
//   clk                    system clock
//   reset                  asynchronous reset, active-low
//   req0/req1              bus request, level, held for the whole burst
//   start0/start1          one-cycle byte start (honoured only from the owner)
//   tx0/tx1, dc0/dc1       byte and D/C value, sampled with start
//   gnt0/gnt1              grant (one-hot or zero)
//   busy0/busy1            byte in flight for that port
//   rx_data                last received byte
//   rx_valid0/rx_valid1    one-cycle pulse, rx_data valid for that port
//   cs0_n/cs1_n            device chip selects, active-low
//   dc                     D/C to the display
//   spi_start/spi_tx       start pulse and byte to the SPI master
//   spi_rx/spi_busy        received byte and busy flag from the SPI master
// -----------------------------------------------------------------------------
module spi_bus_arbiter #(
    parameter int CS_GUARD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       start0,
    input  logic       start1,
    input  logic [7:0] tx0,
    input  logic [7:0] tx1,
    input  logic       dc0,
    input  logic       dc1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       busy0,
    output logic       busy1,
    output logic [7:0] rx_data,
    output logic       rx_valid0,
    output logic       rx_valid1,
    output logic       cs0_n,
    output logic       cs1_n,
    output logic       dc,
    output logic       spi_start,
    output logic [7:0] spi_tx,
    input  logic [7:0] spi_rx,
    input  logic       spi_busy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_OWN    = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_XFER   = 3'd3,
        ST_GUARD  = 3'd4
    } state_t;

    // Terminal count of the guard counter; the counter starts at zero when
    // GUARD is entered, so GUARD lasts exactly CS_GUARD_CYCLES cycles.
    localparam logic [3:0] GUARD_LAST = 4'(CS_GUARD_CYCLES - 1);

    // Registered state and outputs
    state_t     r_state;
    logic       r_owner;
    logic [3:0] r_guard_cnt;
    logic       r_gnt0;
    logic       r_gnt1;
    logic       r_cs0_n;
    logic       r_cs1_n;
    logic       r_busy0;
    logic       r_busy1;
    logic       r_rx_valid0;
    logic       r_rx_valid1;
    logic       r_dc;
    logic       r_spi_start;
    logic [7:0] r_spi_tx;
    logic [7:0] r_rx_data;

    // Next-state values
    state_t     w_state_nxt;
    logic       w_owner_nxt;
    logic [3:0] w_guard_cnt_nxt;
    logic       w_gnt0_nxt;
    logic       w_gnt1_nxt;
    logic       w_cs0_n_nxt;
    logic       w_cs1_n_nxt;
    logic       w_busy0_nxt;
    logic       w_busy1_nxt;
    logic       w_rx_valid0_nxt;
    logic       w_rx_valid1_nxt;
    logic       w_dc_nxt;
    logic       w_spi_start_nxt;
    logic [7:0] w_spi_tx_nxt;
    logic [7:0] w_rx_data_nxt;

    // Owner-side views of the requester inputs
    logic       w_win;
    logic       w_any_req;
    logic       w_own_req;
    logic       w_own_start;
    logic [7:0] w_own_tx;
    logic       w_own_dc;

    assign w_any_req = req0 | req1;

    // Mux the current owner's request, start and data onto common wires
    always_comb begin
        if (r_owner) begin
            w_own_req   = req1;
            w_own_start = start1;
            w_own_tx    = tx1;
            w_own_dc    = dc1;
        end else begin
            w_own_req   = req0;
            w_own_start = start0;
            w_own_tx    = tx0;
            w_own_dc    = dc0;
        end
    end

`ifdef SPI_BUS_ARB_ROUND_ROBIN_EN
    // Port that wins the next simultaneous request; flips to the loser of
    // each grant so the port granted last yields next time.
    logic r_rr_ptr;

    // Winner selection: a lone requester wins, a tie goes to the pointer
    always_comb begin
        if (req0 && req1) begin
            w_win = r_rr_ptr;
        end else if (req1) begin
            w_win = 1'b1;
        end else begin
            w_win = 1'b0;
        end
    end

    // Round-robin pointer update at every grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr <= 1'b0;
        end else if ((r_state == ST_IDLE) && w_any_req) begin
            r_rr_ptr <= ~w_win;
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end
`else
    // Winner selection: fixed priority, port 0 (display) always wins
    always_comb begin
        if (req0) begin
            w_win = 1'b0;
        end else if (req1) begin
            w_win = 1'b1;
        end else begin
            w_win = 1'b0;
        end
    end
`endif

    // Next-state and next-output logic of the arbitration FSM
    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_guard_cnt_nxt = r_guard_cnt;
        w_gnt0_nxt      = r_gnt0;
        w_gnt1_nxt      = r_gnt1;
        w_cs0_n_nxt     = r_cs0_n;
        w_cs1_n_nxt     = r_cs1_n;
        w_busy0_nxt     = r_busy0;
        w_busy1_nxt     = r_busy1;
        w_rx_valid0_nxt = 1'b0;
        w_rx_valid1_nxt = 1'b0;
        w_dc_nxt        = r_dc;
        w_spi_start_nxt = 1'b0;
        w_spi_tx_nxt    = r_spi_tx;
        w_rx_data_nxt   = r_rx_data;

        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_OWN;
                    w_owner_nxt = w_win;
                    w_gnt0_nxt  = ~w_win;
                    w_gnt1_nxt  = w_win;
                    w_cs0_n_nxt = w_win;
                    w_cs1_n_nxt = ~w_win;
                end else begin
                    w_gnt0_nxt  = 1'b0;
                    w_gnt1_nxt  = 1'b0;
                    w_cs0_n_nxt = 1'b1;
                    w_cs1_n_nxt = 1'b1;
                end
            end

            ST_OWN: begin
                // A start beats a simultaneous request drop: the byte is
                // sent first and the release happens on return to OWN.
                if (w_own_start) begin
                    w_state_nxt     = ST_LAUNCH;
                    w_spi_tx_nxt    = w_own_tx;
                    w_dc_nxt        = w_own_dc;
                    w_spi_start_nxt = 1'b1;
                    if (r_owner) begin
                        w_busy1_nxt = 1'b1;
                    end else begin
                        w_busy0_nxt = 1'b1;
                    end
                end else if (!w_own_req) begin
                    w_state_nxt     = ST_GUARD;
                    w_guard_cnt_nxt = 4'd0;
                    w_gnt0_nxt      = 1'b0;
                    w_gnt1_nxt      = 1'b0;
                    w_cs0_n_nxt     = 1'b1;
                    w_cs1_n_nxt     = 1'b1;
                end else begin
                    w_state_nxt = ST_OWN;
                end
            end

            ST_LAUNCH: begin
                if (spi_busy) begin
                    w_state_nxt = ST_XFER;
                end else begin
                    w_state_nxt = ST_LAUNCH;
                end
            end

            ST_XFER: begin
                // Busy low while in XFER marks the end of the byte
                if (!spi_busy) begin
                    w_state_nxt   = ST_OWN;
                    w_rx_data_nxt = spi_rx;
                    w_busy0_nxt   = 1'b0;
                    w_busy1_nxt   = 1'b0;
                    if (r_owner) begin
                        w_rx_valid1_nxt = 1'b1;
                    end else begin
                        w_rx_valid0_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_XFER;
                end
            end

            ST_GUARD: begin
                if (r_guard_cnt >= GUARD_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_guard_cnt_nxt = r_guard_cnt + 4'd1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt0_nxt  = 1'b0;
                w_gnt1_nxt  = 1'b0;
                w_cs0_n_nxt = 1'b1;
                w_cs1_n_nxt = 1'b1;
                w_busy0_nxt = 1'b0;
                w_busy1_nxt = 1'b0;
            end
        endcase
    end

    // State register and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_owner     <= 1'b0;
            r_guard_cnt <= 4'd0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_cs0_n     <= 1'b1;
            r_cs1_n     <= 1'b1;
            r_busy0     <= 1'b0;
            r_busy1     <= 1'b0;
            r_rx_valid0 <= 1'b0;
            r_rx_valid1 <= 1'b0;
            r_dc        <= 1'b0;
            r_spi_start <= 1'b0;
            r_spi_tx    <= 8'h00;
            r_rx_data   <= 8'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_guard_cnt <= w_guard_cnt_nxt;
            r_gnt0      <= w_gnt0_nxt;
            r_gnt1      <= w_gnt1_nxt;
            r_cs0_n     <= w_cs0_n_nxt;
            r_cs1_n     <= w_cs1_n_nxt;
            r_busy0     <= w_busy0_nxt;
            r_busy1     <= w_busy1_nxt;
            r_rx_valid0 <= w_rx_valid0_nxt;
            r_rx_valid1 <= w_rx_valid1_nxt;
            r_dc        <= w_dc_nxt;
            r_spi_start <= w_spi_start_nxt;
            r_spi_tx    <= w_spi_tx_nxt;
            r_rx_data   <= w_rx_data_nxt;
        end
    end

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign cs0_n     = r_cs0_n;
    assign cs1_n     = r_cs1_n;
    assign busy0     = r_busy0;
    assign busy1     = r_busy1;
    assign rx_valid0 = r_rx_valid0;
    assign rx_valid1 = r_rx_valid1;
    assign rx_data   = r_rx_data;
    assign dc        = r_dc;
    assign spi_start = r_spi_start;
    assign spi_tx    = r_spi_tx;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_bus_arbiter
//
// Self-checking bench for spi_bus_arbiter. Requesters and the SPI master are
// driven from tasks; expected grants, latencies and data come from a
// transaction-level model (winner choice, guard timing, byte echo).
// -----------------------------------------------------------------------------
module tb_spi_bus_arbiter;

    localparam int G = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1, start0, start1;
    logic [7:0] tx0, tx1;
    logic       dc0, dc1;
    logic       gnt0, gnt1, busy0, busy1;
    logic [7:0] rx_data;
    logic       rx_valid0, rx_valid1;
    logic       cs0_n, cs1_n;
    logic       dc, spi_start;
    logic [7:0] spi_tx;
    logic [7:0] spi_rx;
    logic       spi_busy;

    int n_pass  = 0;
    int n_total = 0;
    bit rr_next;      // model: port preferred on the next tie

    spi_bus_arbiter #(.CS_GUARD_CYCLES(G)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .start0(start0), .start1(start1),
        .tx0(tx0), .tx1(tx1), .dc0(dc0), .dc1(dc1),
        .gnt0(gnt0), .gnt1(gnt1), .busy0(busy0), .busy1(busy1),
        .rx_data(rx_data), .rx_valid0(rx_valid0), .rx_valid1(rx_valid1),
        .cs0_n(cs0_n), .cs1_n(cs1_n), .dc(dc),
        .spi_start(spi_start), .spi_tx(spi_tx),
        .spi_rx(spi_rx), .spi_busy(spi_busy)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: winner of a request set
    function automatic bit pick(input bit both, input bit port);
        if (!both) return port;
`ifdef SPI_BUS_ARB_ROUND_ROBIN_EN
        return rr_next;
`else
        return 1'b0;
`endif
    endfunction

    // Model: edges from raising a request to the grant, given the number of
    // the negedge after the release edge on which the request is raised.
    function automatic int grant_wait(input int gap);
        if (gap <= G + 1) return G + 2 - gap;
        return 1;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_gnt0"}, 32'(gnt0), 32'd0);
        check_val({tag, "_gnt1"}, 32'(gnt1), 32'd0);
        check_val({tag, "_cs0_n"}, 32'(cs0_n), 32'd1);
        check_val({tag, "_cs1_n"}, 32'(cs1_n), 32'd1);
        check_val({tag, "_busy"}, 32'({busy1, busy0}), 32'd0);
        check_val({tag, "_rxv"}, 32'({rx_valid1, rx_valid0}), 32'd0);
        check_val({tag, "_spi_start"}, 32'(spi_start), 32'd0);
        check_val({tag, "_spi_tx"}, 32'(spi_tx), 32'd0);
        check_val({tag, "_rx_data"}, 32'(rx_data), 32'd0);
        check_val({tag, "_dc"}, 32'(dc), 32'd0);
    endtask

    task automatic set_start(input bit p, input logic v, input logic [7:0] t, input logic d);
        if (p) begin start1 = v; tx1 = t; dc1 = d; end
        else   begin start0 = v; tx0 = t; dc0 = d; end
    endtask

    // Raise requests on the next negedge and check the grant after wait_e edges.
    // Leaves the bench positioned at a negedge.
    task automatic grant_phase(input bit both, input bit port, input int wait_e, output bit win);
        @(negedge clk);
        if (both) begin req0 = 1'b1; req1 = 1'b1; end
        else if (port) req1 = 1'b1;
        else req0 = 1'b1;
        win = pick(both, port);
        if (wait_e > 1) begin
            repeat (wait_e - 1) @(posedge clk);
            #1;
            check_val("guard_no_gnt", 32'({gnt1, gnt0}), 32'd0);
            check_val("guard_cs_high", 32'({cs1_n, cs0_n}), 32'd3);
        end
        @(posedge clk);
        #1;
        check_val("gnt_win", 32'(win ? gnt1 : gnt0), 32'd1);
        check_val("gnt_other", 32'(win ? gnt0 : gnt1), 32'd0);
        check_val("cs_win", 32'(win ? cs1_n : cs0_n), 32'd0);
        check_val("cs_other", 32'(win ? cs0_n : cs1_n), 32'd1);
        rr_next = ~win;
        @(negedge clk);
    endtask

    // Run nbytes bytes for owner win, then release. Starts at a negedge,
    // ends just after the release edge.
    task automatic burst(input bit win, input int nbytes, input bit drop_mid, input bit directed);
        logic [7:0] txv, rxv;
        logic       dcv;
        int         len;
        bit         inj, nown;
        for (int b = 0; b < nbytes; b++) begin
            txv  = directed ? 8'h2A : 8'($urandom);
            dcv  = directed ? 1'b0 : 1'($urandom);
            rxv  = directed ? 8'h5C : 8'($urandom);
            len  = directed ? 2 : int'($urandom_range(1, 4));
            inj  = directed ? 1'b0 : 1'($urandom);
            nown = directed ? 1'b0 : 1'($urandom);
            set_start(win, 1'b1, txv, dcv);
            if (nown) set_start(~win, 1'b1, ~txv, ~dcv);
            @(posedge clk);
            #1;
            check_val("spi_start", 32'(spi_start), 32'd1);
            check_val("spi_tx", 32'(spi_tx), 32'(txv));
            check_val("dc", 32'(dc), 32'(dcv));
            check_val("busy_win", 32'(win ? busy1 : busy0), 32'd1);
            check_val("busy_other", 32'(win ? busy0 : busy1), 32'd0);
            check_val("cs_other_high", 32'(win ? cs0_n : cs1_n), 32'd1);
            check_val("rxv_one_pulse", 32'(win ? rx_valid1 : rx_valid0), 32'd0);
            @(negedge clk);
            start0 = 1'b0; start1 = 1'b0;
            spi_busy = 1'b1;
            for (int c = 0; c < len; c++) begin
                @(posedge clk);
                #1;
                check_val("spi_start_pulse", 32'(spi_start), 32'd0);
                check_val("busy_hold", 32'(win ? busy1 : busy0), 32'd1);
                @(negedge clk);
                start0 = 1'b0; start1 = 1'b0;
                if (c == 0 && inj) set_start(win, 1'b1, ~txv, ~dcv);
                if (c == 0 && drop_mid && b == nbytes - 1) begin req0 = 1'b0; req1 = 1'b0; end
                if (c == len - 1) begin spi_busy = 1'b0; spi_rx = rxv; end
            end
            @(posedge clk);
            #1;
            check_val("rx_valid_win", 32'(win ? rx_valid1 : rx_valid0), 32'd1);
            check_val("rx_valid_other", 32'(win ? rx_valid0 : rx_valid1), 32'd0);
            check_val("rx_data", 32'(rx_data), 32'(rxv));
            check_val("busy_clear", 32'({busy1, busy0}), 32'd0);
            check_val("no_start_busy", 32'(spi_start), 32'd0);
            check_val("cs_held", 32'(win ? cs1_n : cs0_n), 32'd0);
            check_val("spi_tx_hold", 32'(spi_tx), 32'(txv));
            @(negedge clk);
            start0 = 1'b0; start1 = 1'b0;
        end
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk);
        #1;
        check_val("rel_gnt", 32'({gnt1, gnt0}), 32'd0);
        check_val("rel_cs", 32'(win ? cs1_n : cs0_n), 32'd1);
        check_val("rel_start", 32'(spi_start), 32'd0);
    endtask

    initial begin
        bit win;
        int gap, nb;
        bit both, port, drop;

        reset = 1'b0;
        req0 = 1'b1; req1 = 1'b0;
        start0 = 1'b0; start1 = 1'b0;
        tx0 = 8'h00; tx1 = 8'h00; dc0 = 1'b0; dc1 = 1'b0;
        spi_rx = 8'h00; spi_busy = 1'b0;
        rr_next = 1'b0;

        // Reset held with req0 high: nothing granted
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst_rel_gnt0", 32'(gnt0), 32'd1);
        check_val("rst_rel_cs0_n", 32'(cs0_n), 32'd0);
        check_val("rst_rel_gnt1", 32'(gnt1), 32'd0);
        rr_next = 1'b1;
        @(negedge clk);

        // Single directed byte 0x2A -> echo 0x5C
        burst(1'b0, 1, 1'b0, 1'b1);

        // Request drop mid-byte, then port 1 waits out the guard
        grant_phase(1'b0, 1'b0, grant_wait(1), win);
        burst(win, 2, 1'b1, 1'b0);
        grant_phase(1'b0, 1'b1, grant_wait(1), win);

        // Async reset during XFER
        set_start(1'b1, 1'b1, 8'hC3, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        start1 = 1'b0;
        spi_busy = 1'b1;
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        spi_busy = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        rr_next = 1'b0;
        @(posedge clk);
        #1;
        check_val("post_rst_idle", 32'({gnt1, gnt0, cs1_n, cs0_n}), 32'h3);

        // Two back-to-back contentions from a fresh reset
        grant_phase(1'b1, 1'b0, 1, win);
        burst(win, 1, 1'b0, 1'b0);
        grant_phase(1'b1, 1'b0, grant_wait(1), win);
        burst(win, 1, 1'b0, 1'b0);

        // Randomized sessions
        for (int s = 0; s < 30; s++) begin
            gap  = int'($urandom_range(1, 5));
            both = 1'($urandom);
            port = 1'($urandom);
            nb   = int'($urandom_range(0, 3));
            drop = (nb > 0) && 1'($urandom);
            if (gap > 1) repeat (gap - 1) @(posedge clk);
            grant_phase(both, port, grant_wait(gap), win);
            burst(win, nb, drop, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
